// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - two-channel synchronizing debouncer with edge pulses and a saturating transition count
module input_debounce #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       a,
    output logic       b,
    output logic       a_rise,
    output logic       a_fall,
    output logic       b_rise,
    output logic       b_fall,
    output logic [7:0] change_count
);

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    // Bit 0 is channel A, bit 1 is channel B throughout.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      level_q, level_d;
    logic [1:0]      rise_q, rise_d;
    logic [1:0]      fall_q, fall_d;
    logic [1:0][7:0] cnt_q, cnt_d;
    logic [7:0]      change_count_q, change_count_d;
    logic [8:0]      count_sum;

    always_comb begin
        sync1_d = {raw_b, raw_a};
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == LAST) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
        // A 9-bit sum lets the carry flag overflow so the count pins at 255.
        count_sum = {1'b0, change_count_q}
                  + 9'(rise_d[0] | fall_d[0])
                  + 9'(rise_d[1] | fall_d[1]);
        change_count_d = count_sum[8] ? 8'hFF : count_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            level_q        <= '0;
            rise_q         <= '0;
            fall_q         <= '0;
            cnt_q          <= '0;
            change_count_q <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            level_q        <= level_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            cnt_q          <= cnt_d;
            change_count_q <= change_count_d;
        end
    end

    assign a            = level_q[0];
    assign b            = level_q[1];
    assign a_rise       = rise_q[0];
    assign a_fall       = fall_q[0];
    assign b_rise       = rise_q[1];
    assign b_fall       = fall_q[1];
    assign change_count = change_count_q;

endmodule
